// File: rtl/leaper_gen.sv
// leaper_gen: knight/king move generator. Loads a source board over the
// master port, evaluates the eight leaper moves of the piece at
// (src_x, src_y) and writes one complete successor board per legal move.
//
// Handshake (both ports): a request is held with address, strobe and write
// data unchanged while waitrequest is high; it is taken at the clock edge
// where the strobe is high and waitrequest is low. Read data is returned
// later with master_readdatavalid, and only one read is outstanding.
module leaper_gen #(
  parameter int BOARD_DIM = 8,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              slave_waitrequest,
  input  logic [3:0]        slave_address,
  input  logic              slave_read,
  output logic [31:0]       slave_readdata,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  input  logic              master_waitrequest,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic [31:0]       master_readdata,
  input  logic              master_readdatavalid,
  output logic              master_write,
  output logic [31:0]       master_writedata,
  output logic [2:0]        dbg_state_o
);

  localparam int NSQ       = BOARD_DIM * BOARD_DIM;
  localparam int IDX_W     = $clog2(NSQ);
  localparam int BRD_BYTES = 4 * NSQ;
  localparam logic [IDX_W-1:0] LAST_SQ = IDX_W'(NSQ - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD_RD = 3'd1, LOAD_WT = 3'd2, EVAL = 3'd3,
    WR_SQ = 3'd4, NEXT_BRD = 3'd5, DONE = 3'd6
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] src_base_q, dst_base_q, m_addr_q;
  logic [31:0]       src_x_q, src_y_q, m_wdata_q;
  logic              mode_q, m_rd_q, m_wr_q;
  logic [7:0]        mask_q, pend_q;
  logic [3:0]        count_q, brd_q;
  logic [IDX_W-1:0]  sq_q;
  logic [2:0]        mv_q;
  logic [7:0]        buf_q [NSQ];

  // Offsets packed as {dx, dy}, each 6-bit two's complement.
  function automatic logic [11:0] move_off(input logic king, input logic [2:0] i);
    logic [11:0] r;
    r = '0;
    if (!king) begin
      case (i)
        3'd0: r = {6'h01, 6'h02};
        3'd1: r = {6'h3F, 6'h02};
        3'd2: r = {6'h01, 6'h3E};
        3'd3: r = {6'h3F, 6'h3E};
        3'd4: r = {6'h02, 6'h01};
        3'd5: r = {6'h3E, 6'h01};
        3'd6: r = {6'h02, 6'h3F};
        default: r = {6'h3E, 6'h3F};
      endcase
    end else begin
      case (i)
        3'd0: r = {6'h01, 6'h00};
        3'd1: r = {6'h3F, 6'h00};
        3'd2: r = {6'h00, 6'h01};
        3'd3: r = {6'h00, 6'h3F};
        3'd4: r = {6'h01, 6'h01};
        3'd5: r = {6'h3F, 6'h01};
        3'd6: r = {6'h01, 6'h3F};
        default: r = {6'h3F, 6'h3F};
      endcase
    end
    return r;
  endfunction

  logic              src_ok, nx_in, ny_in, mv_valid;
  logic [5:0]        nx, ny;
  logic [11:0]       off;
  logic [IDX_W-1:0]  src_idx, dst_idx, sq_nxt;
  logic [7:0]        src_piece, dst_piece, wr_piece, mask_nxt;
  logic [3:0]        count_nxt;
  logic [2:0]        pend_low;
  logic [ADDR_W-1:0] rd_addr_nxt, wr_addr;
  logic              unused_bits;

  assign unused_bits = ^master_readdata[31:8];

  // Move evaluation for move mv_q; also supplies the destination square while writing.
  always_comb begin
    src_ok    = (src_x_q < 32'(BOARD_DIM)) && (src_y_q < 32'(BOARD_DIM));
    src_idx   = IDX_W'(src_y_q[3:0]) * IDX_W'(BOARD_DIM) + IDX_W'(src_x_q[3:0]);
    src_piece = src_ok ? buf_q[src_idx] : 8'd0;
    off       = move_off(mode_q, mv_q);
    nx        = {2'b00, src_x_q[3:0]} + off[11:6];
    ny        = {2'b00, src_y_q[3:0]} + off[5:0];
    nx_in     = !nx[5] && (nx[4:0] < 5'(BOARD_DIM));
    ny_in     = !ny[5] && (ny[4:0] < 5'(BOARD_DIM));
    dst_idx   = IDX_W'(ny[3:0]) * IDX_W'(BOARD_DIM) + IDX_W'(nx[3:0]);
    dst_piece = (nx_in && ny_in) ? buf_q[dst_idx] : 8'd0;
    mv_valid  = src_ok && (src_piece != 8'd0) && nx_in && ny_in &&
                ((dst_piece == 8'd0) || (dst_piece[7] != src_piece[7]));
    mask_nxt          = mask_q;
    mask_nxt[mv_q]    = mv_valid;
    count_nxt = count_q + {3'b000, mv_valid};
    wr_piece  = (sq_q == dst_idx) ? src_piece :
                (sq_q == src_idx) ? 8'd0 : buf_q[sq_q];
    sq_nxt      = sq_q + IDX_W'(1);
    rd_addr_nxt = src_base_q + ADDR_W'({sq_nxt, 2'b00});
    wr_addr     = dst_base_q + ADDR_W'(brd_q) * ADDR_W'(BRD_BYTES) + ADDR_W'({sq_q, 2'b00});
  end

  // Lowest move still waiting for its output board.
  always_comb begin
    pend_low = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) pend_low = 3'(i);
    end
  end

  // Capture returned source squares into the local board copy.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == LOAD_WT && master_readdatavalid) buf_q[sq_q] <= master_readdata[7:0];
  end

  // Main controller: register file, board load, move evaluation, board writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      src_base_q <= '1;
      dst_base_q <= '1;
      src_x_q    <= '1;
      src_y_q    <= '1;
      mode_q     <= 1'b0;
      mask_q     <= '0;
      count_q    <= '0;
      brd_q      <= '0;
      pend_q     <= '0;
      sq_q       <= '0;
      mv_q       <= '0;
      m_rd_q     <= 1'b0;
      m_wr_q     <= 1'b0;
      m_addr_q   <= '1;
      m_wdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (slave_write) begin
            case (slave_address)
              4'd0: begin
                mask_q   <= '0;
                count_q  <= '0;
                brd_q    <= '0;
                sq_q     <= '0;
                m_rd_q   <= 1'b1;
                m_addr_q <= src_base_q;
                state_q  <= LOAD_RD;
              end
              4'd1: src_base_q <= ADDR_W'(slave_writedata);
              4'd2: dst_base_q <= ADDR_W'(slave_writedata);
              4'd3: src_x_q    <= slave_writedata;
              4'd4: src_y_q    <= slave_writedata;
              4'd5: mode_q     <= slave_writedata[0];
              default: ;
            endcase
          end
        end
        LOAD_RD: begin
          if (!master_waitrequest) begin
            m_rd_q   <= 1'b0;
            m_addr_q <= '1;
            state_q  <= LOAD_WT;
          end
        end
        LOAD_WT: begin
          if (master_readdatavalid) begin
            if (sq_q == LAST_SQ) begin
              mv_q    <= '0;
              state_q <= EVAL;
            end else begin
              sq_q     <= sq_nxt;
              m_rd_q   <= 1'b1;
              m_addr_q <= rd_addr_nxt;
              state_q  <= LOAD_RD;
            end
          end
        end
        EVAL: begin
          mask_q  <= mask_nxt;
          count_q <= count_nxt;
          if (mv_q == 3'd7) begin
            pend_q  <= mask_nxt;
            state_q <= (count_nxt == 4'd0) ? DONE : NEXT_BRD;
          end else begin
            mv_q <= mv_q + 3'd1;
          end
        end
        NEXT_BRD: begin
          mv_q             <= pend_low;
          pend_q[pend_low] <= 1'b0;
          sq_q             <= '0;
          state_q          <= WR_SQ;
        end
        WR_SQ: begin
          // Alternate between presenting a square and waiting for its acceptance.
          if (!m_wr_q) begin
            m_wr_q    <= 1'b1;
            m_addr_q  <= wr_addr;
            m_wdata_q <= {{24{wr_piece[7]}}, wr_piece};
          end else if (!master_waitrequest) begin
            m_wr_q   <= 1'b0;
            m_addr_q <= '1;
            if (sq_q == LAST_SQ) begin
              brd_q   <= brd_q + 4'd1;
              state_q <= (pend_q == 8'd0) ? DONE : NEXT_BRD;
            end else begin
              sq_q <= sq_nxt;
            end
          end
        end
        DONE: begin
          if (slave_read && slave_address == 4'd0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign slave_waitrequest = !(state_q == IDLE || state_q == DONE);
  assign slave_readdata    = {16'd0, mask_q, 4'd0, count_q};
  assign master_address    = m_addr_q;
  assign master_read       = m_rd_q;
  assign master_write      = m_wr_q;
  assign master_writedata  = m_wdata_q;
  assign dbg_state_o       = state_q;

endmodule
